// File: rtl/restoring_div_pkg.sv
// Shared declarations for the restoring divider: FSM state encoding and counter sizing.
// Latency: none (types and constant functions only).
// Backpressure: none.
package restoring_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bits needed to hold an iteration count running from width down to 0.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One shift-subtract-restore step of a restoring divider (one quotient bit).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module restoring_div_step
    import restoring_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH:0]   r_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             fits;

    // Shift {R,Q} left, trial-subtract D, keep the difference only if it stayed non-negative.
    always_comb begin
        // The partial remainder is always below D, so r_in[WIDTH] is zero in normal
        // operation and the shifted value fits in WIDTH+1 bits.
        shifted = {r_in[WIDTH-1:0], q_in[WIDTH-1]};
        // One extra bit above WIDTH+1 holds the borrow, i.e. the sign of T.
        trial   = {1'b0, shifted} - {2'b00, d_in};
        // A set top bit of R would mean the true shifted value exceeds any divisor.
        fits    = r_in[WIDTH] | ~trial[WIDTH+1];
        r_out   = fits ? trial[WIDTH:0] : shifted;
        q_out   = {q_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/restoring_divider_n.sv
// Multi-cycle restoring divider, WIDTH-bit quotient/remainder; SIGNED_DIV_EN selects two's complement mode.
// Latency: done pulses WIDTH+1 edges after the accepted start (1 edge for a zero divisor).
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, nothing is queued.
module restoring_divider_n
    import restoring_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   step_r;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] fix_quot;
    logic [WIDTH-1:0] fix_rem;

`ifdef SIGNED_DIV_EN
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
`endif

    restoring_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_in  (r_q),
        .q_in  (q_q),
        .d_in  (d_q),
        .r_out (step_r),
        .q_out (step_q)
    );

`ifdef SIGNED_DIV_EN
    // Operand magnitudes and final sign fix-up; the most-negative value maps onto itself,
    // which read as unsigned is exactly its magnitude, so MIN / -1 wraps back to MIN.
    always_comb begin
        dvd_mag  = dividend[WIDTH-1] ? -dividend : dividend;
        dvs_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
        fix_quot = qneg_q ? -q_q : q_q;
        fix_rem  = rneg_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
    end
`else
    // Unsigned build: operands go in as-is and the results are a plain copy.
    always_comb begin
        dvd_mag  = dividend;
        dvs_mag  = divisor;
        fix_quot = q_q;
        fix_rem  = r_q[WIDTH-1:0];
    end
`endif

    // Next-state logic for the FSM, iteration datapath and result registers.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        // Zero divisor: results are known immediately. Passing through FIX
                        // keeps the done/busy timing of a one-step division.
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = FIX;
                    end else begin
                        r_d     = '0;
                        q_d     = dvd_mag;
                        d_d     = dvs_mag;
                        count_d = CW'(WIDTH);
`ifdef SIGNED_DIV_EN
                        qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        rneg_d  = dividend[WIDTH-1];
`endif
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                r_d     = step_r;
                q_d     = step_q;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // A zero-divisor result was already loaded when the request was taken.
                if (!dbz_q) begin
                    quot_d = fix_quot;
                    rem_d  = fix_rem;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Status flags are registered copies of where the FSM is heading.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset; reset discards any division in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule
